// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: fetch, load/store and SRAM-side signals of the unified-memory arbiter.
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;
    logic              data_req;
    logic              data_wr;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;
    logic              sram_en;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    modport master (
        output inst_req, inst_addr, data_req, data_wr, data_addr, data_wdata, sram_rdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata
    );

    modport slave (
        input  inst_req, inst_addr, data_req, data_wr, data_addr, data_wdata, sram_rdata,
        output inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port synchronous SRAM between fetch and load/store ports,
// data-first with a streak bound so fetch cannot starve.
module sram_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4
) (
    input logic clk,
    input logic reset,
    sram_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    owner_t            resp_owner, owner_nxt;
    logic              resp_wr, wr_nxt;
    logic [3:0]        streak, streak_nxt;
    logic              grant_inst, grant_data;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] resp_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_owner <= OWN_NONE;
            resp_wr    <= 1'b0;
            streak     <= 4'd0;
        end else begin
            resp_owner <= owner_nxt;
            resp_wr    <= wr_nxt;
            streak     <= streak_nxt;
        end
    end

    // Grants are masked during reset so nothing reaches the SRAM or requesters.
    always_comb begin
        grant_data = !reset && bus.data_req && (!bus.inst_req || streak < STREAK_MAX);
        grant_inst = !reset && bus.inst_req && !grant_data;
        owner_nxt  = grant_inst ? OWN_INST : grant_data ? OWN_DATA : OWN_NONE;
        wr_nxt     = grant_data && bus.data_wr;
        streak_nxt = (grant_inst || !bus.inst_req) ? 4'd0 : grant_data ? streak + 4'd1 : streak;
    end

    always_comb begin
        grant_addr       = grant_data ? bus.data_addr : grant_inst ? bus.inst_addr : '0;
        resp_data        = bus.sram_rdata;
        bus.inst_addr_ok = grant_inst;
        bus.data_addr_ok = grant_data;
        bus.sram_en      = grant_inst || grant_data;
        bus.sram_we      = grant_data && bus.data_wr;
        bus.sram_addr    = grant_addr;
        bus.sram_wdata   = grant_data ? bus.data_wdata : '0;
        bus.inst_data_ok = resp_owner == OWN_INST;
        bus.inst_rdata   = (resp_owner == OWN_INST) ? resp_data : '0;
        bus.data_data_ok = resp_owner == OWN_DATA;
        bus.data_rdata   = (resp_owner == OWN_DATA && !resp_wr) ? resp_data : '0;
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed and random traffic against a rule-level model of the arbiter
// with an SRAM behavioural model on the memory side.
module tb_sram_port_arbiter;
    localparam int MAX_STREAK = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(MAX_STREAK)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];

    always @(posedge clk) begin
        if (bus.sram_en) begin
            if (bus.sram_we) mem[bus.sram_addr[11:2]] <= bus.sram_wdata;
            else bus.sram_rdata <= mem[bus.sram_addr[11:2]];
        end
    end

    int          checks = 0;
    int          failures = 0;
    int          exp_streak = 0;
    int          exp_kind = 0;
    logic [31:0] exp_data = '0;
    bit          exp_wr, exp_gi, exp_gd, obs_gd;
    logic [9:0]  pat;

    function automatic int widx(logic [31:0] a);
        return int'((a / 4) % 1024);
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check grant and response outputs mid-cycle, then advance the model past the edge.
    task automatic step();
        logic [31:0] ea;
        @(negedge clk);
        if (reset) begin
            exp_kind = 0;
            exp_streak = 0;
        end
        exp_gd = !reset && bus.data_req && (!bus.inst_req || exp_streak < MAX_STREAK);
        exp_gi = !reset && bus.inst_req && !exp_gd;
        ea = exp_gd ? bus.data_addr : exp_gi ? bus.inst_addr : 32'd0;
        obs_gd = bus.data_addr_ok;
        chk("inst_addr_ok", bus.inst_addr_ok, exp_gi);
        chk("data_addr_ok", bus.data_addr_ok, exp_gd);
        chk("sram_en", bus.sram_en, exp_gi || exp_gd);
        chk("sram_we", bus.sram_we, exp_gd && bus.data_wr);
        chk("sram_addr", bus.sram_addr, ea);
        chk("sram_wdata", bus.sram_wdata, exp_gd ? bus.data_wdata : 32'd0);
        chk("streak", dut.streak, exp_streak);
        chk("inst_data_ok", bus.inst_data_ok, exp_kind == 1);
        chk("inst_rdata", bus.inst_rdata, exp_kind == 1 ? exp_data : 32'd0);
        chk("data_data_ok", bus.data_data_ok, exp_kind == 2);
        chk("data_rdata", bus.data_rdata, (exp_kind == 2 && !exp_wr) ? exp_data : 32'd0);
        if (exp_gi) begin
            exp_kind = 1;
            exp_wr = 1'b0;
            exp_data = ref_mem[widx(bus.inst_addr)];
            exp_streak = 0;
        end else if (exp_gd) begin
            exp_kind = 2;
            exp_wr = bus.data_wr;
            exp_data = exp_wr ? 32'd0 : ref_mem[widx(bus.data_addr)];
            if (exp_wr) ref_mem[widx(bus.data_addr)] = bus.data_wdata;
            exp_streak = bus.inst_req ? exp_streak + 1 : 0;
        end else begin
            exp_kind = 0;
            exp_streak = 0;
        end
        @(posedge clk);
        #1;
        if (reset) begin
            exp_kind = 0;
            exp_streak = 0;
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'h5A000000 ^ (32'(i) * 32'h9E3779B1);
            ref_mem[i] = mem[i];
        end
        bus.inst_req = 0; bus.inst_addr = '0;
        bus.data_req = 0; bus.data_wr = 0; bus.data_addr = '0; bus.data_wdata = '0;

        // reset held for two cycles
        step();
        step();
        reset = 0;

        // fetch only
        bus.inst_req = 1;
        for (int i = 0; i < 3; i++) begin
            bus.inst_addr = 32'h1c000000 + 32'(i * 4);
            step();
        end
        bus.inst_req = 0;
        step();

        // store then load to the same address
        bus.data_req = 1; bus.data_wr = 1; bus.data_addr = 32'h100; bus.data_wdata = 32'hDEADBEEF;
        step();
        bus.data_wr = 0; bus.data_wdata = '0;
        step();
        chk("load_after_store", bus.data_rdata, 32'hDEADBEEF);
        bus.data_req = 0;
        step();

        // conflict: data wins until the streak bound, then fetch
        bus.inst_req = 1; bus.inst_addr = 32'h1c000010;
        bus.data_req = 1; bus.data_wr = 0;
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            bus.data_addr = 32'($urandom_range(0, 63)) << 2;
            step();
            pat = {pat[8:0], obs_gd};
        end
        chk("conflict_pattern", pat, 10'b1111011110);
        bus.inst_req = 0; bus.data_req = 0;
        step();

        // streak clears when inst_req drops for a cycle
        bus.inst_req = 1; bus.data_req = 1;
        for (int i = 0; i < 3; i++) step();
        bus.inst_req = 0;
        step();
        bus.inst_req = 1;
        pat = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            pat = {pat[8:0], obs_gd};
        end
        chk("clear_pattern", pat, 10'b0000011110);
        bus.inst_req = 0; bus.data_req = 0;
        step();

        // random traffic, requests held until granted
        for (int i = 0; i < 400; i++) begin
            if (!bus.inst_req || exp_gi) begin
                bus.inst_req = 1'($urandom_range(0, 1));
                bus.inst_addr = 32'($urandom_range(0, 63)) << 2;
            end
            if (!bus.data_req || exp_gd) begin
                bus.data_req = 1'($urandom_range(0, 1));
                bus.data_wr = 1'($urandom_range(0, 1));
                bus.data_addr = 32'($urandom_range(0, 63)) << 2;
                bus.data_wdata = $urandom;
            end
            step();
        end
        bus.inst_req = 0; bus.data_req = 0;
        step();

        // reset asserted while a load response is in flight
        bus.data_req = 1; bus.data_wr = 0; bus.data_addr = 32'h20;
        step();
        bus.data_req = 0;
        #2 reset = 1;
        step();
        chk("rst_drop_data_ok", bus.data_data_ok, 1'b0);
        bus.inst_req = 1; bus.inst_addr = 32'h1c000000;
        step();
        reset = 0;
        step();
        bus.inst_req = 0;
        step();

        // idle
        step();
        chk("idle_sram_en", bus.sram_en, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
